// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register:
// occupancy states, ID/EX control-bit layout and default widths.
package pipe_pkg;

    // Occupancy of the stage: main slot empty, main full, main and skid full
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // ID/EX control-bus bit positions
    localparam int unsigned CTRL_REG_DST    = 0;
    localparam int unsigned CTRL_REG_WRITE  = 1;
    localparam int unsigned CTRL_ALU_SRC    = 2;
    localparam int unsigned CTRL_MEM_READ   = 3;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_BRANCH     = 6;
    localparam int unsigned CTRL_JUMP       = 7;
    localparam int unsigned CTRL_ALU_CTL_LO = 8;
    localparam int unsigned CTRL_ALU_CTL_HI = 11;

    // Default bus widths: 8 flags + 4-bit ALU control; 5-bit dest + 6 x 32-bit words
    localparam int unsigned CTRL_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 197;

    // Bubble control word: every write/mem/branch/jump flag deasserted
    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL_DEF = '0;

endpackage

// File: rtl/pipe_slot.sv
// One {ctrl, data} holding register with load enable and synchronous clear.
module pipe_slot #(
    parameter int unsigned        CTRL_W   = 12,
    parameter int unsigned        DATA_W   = 197,
    parameter logic [CTRL_W-1:0]  CLR_CTRL = '0
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clear to the bubble word, otherwise capture on load
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_ctrl <= CLR_CTRL;
            r_data <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// flush, bubble NOP control, optional 2-entry skid and saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = CTRL_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter logic [CTRL_W-1:0] NOP_CTRL    = '0,
    parameter bit                SKID        = 1'b1,
    parameter int unsigned       STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e            r_state;
    pipe_state_e            w_next_state;
    logic                   r_in_ready;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_out_valid;
    logic                   w_acc;
    logic                   w_dq;
    logic                   w_main_load;
    logic                   w_skid_load;
    logic                   w_main_from_skid;

    logic [CTRL_W-1:0]      w_main_ctrl;
    logic [DATA_W-1:0]      w_main_data;
    logic [CTRL_W-1:0]      w_skid_ctrl;
    logic [DATA_W-1:0]      w_skid_data;
    logic [CTRL_W-1:0]      w_main_d_ctrl;
    logic [DATA_W-1:0]      w_main_d_data;

    assign w_out_valid = (r_state != EMPTY);
    assign w_acc       = in_valid && in_ready;
    assign w_dq        = w_out_valid && out_ready;

    // Skid mode presents a registered ready; single-entry mode frees the slot
    // in the same cycle it is drained, so ready must look at out_ready.
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready = r_in_ready;
        end else begin : g_ready_comb
            assign in_ready = !w_out_valid || out_ready;
        end
    endgenerate

    // Next occupancy and slot load enables; flush discards held and incoming entries
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_next_state = BUSY;
                    w_main_load  = 1'b1;
                end
            end
            BUSY: begin
                if (w_acc && w_dq) begin
                    w_main_load  = 1'b1;
                end else if (w_acc) begin
                    w_next_state = FULL;
                    w_skid_load  = 1'b1;
                end else if (w_dq) begin
                    w_next_state = EMPTY;
                end
            end
            FULL: begin
                if (w_dq) begin
                    w_next_state     = BUSY;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
        if (flush) begin
            w_next_state = EMPTY;
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
        end
    end

    // Occupancy state and registered ready (ready whenever the skid stays free)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != FULL);
        end
    end

    // The older skid entry refills main when draining from FULL
    assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_CTRL (NOP_CTRL)
    ) u_main (
        .clk    (clk),
        .i_clr  (!rst_n),
        .i_load (w_main_load),
        .i_ctrl (w_main_d_ctrl),
        .i_data (w_main_d_data),
        .o_ctrl (w_main_ctrl),
        .o_data (w_main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CLR_CTRL (NOP_CTRL)
            ) u_skid (
                .clk    (clk),
                .i_clr  (!rst_n),
                .i_load (w_skid_load),
                .i_ctrl (in_ctrl),
                .i_data (in_data),
                .o_ctrl (w_skid_ctrl),
                .o_data (w_skid_data)
            );
        end else begin : g_no_skid
            assign w_skid_ctrl = NOP_CTRL;
            assign w_skid_data = '0;
        end
    endgenerate

    // Saturating count of stalled cycles; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? w_main_ctrl : NOP_CTRL;
    assign out_data  = w_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default skid build, a 3-bit stall
// counter build sharing its inputs, and a single-entry build with a scoreboard.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 12;
    localparam int unsigned DW = 197;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;

    logic          s3_in_ready, s3_out_valid;
    logic [CW-1:0] s3_out_ctrl;
    logic [DW-1:0] s3_out_data;
    logic [2:0]    s3_stall_cnt;

    logic          z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [3:0]    z_in_ctrl, z_out_ctrl;
    logic [15:0]   z_in_data, z_out_data, z_stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.STALL_CNT_W(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s3_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s3_out_valid), .out_ready(out_ready), .out_ctrl(s3_out_ctrl), .out_data(s3_out_data),
        .stall_cnt(s3_stall_cnt)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(16), .SKID(1'b0), .STALL_CNT_W(16)) dut_z (
        .clk(clk), .rst_n(rst_n), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .stall_cnt(z_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int unsigned d, input int unsigned c);
        in_valid = v;
        in_data  = DW'(d);
        in_ctrl  = CW'(c);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] q[$];
        logic        exp_v, acc, dq;
        logic [15:0] seq;
        int          z_stalls;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0, 0);
        z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_ctrl = '0; z_in_data = '0;
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_ready", 64'(in_ready),  64'd1);
        rst_n = 1'b1;

        // Streaming 1..8 with 1-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, i * 3);
            tick();
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_data",  64'(out_data),  64'(i));
            check("t1_ctrl",  64'(out_ctrl),  64'(i * 3));
            check("t1_ready", 64'(in_ready),  64'd1);
        end
        drive(1'b0, 0, 0);
        tick();
        check("t1_drain_valid", 64'(out_valid), 64'd0);
        check("t1_drain_ctrl",  64'(out_ctrl),  64'd0);
        check("t1_stall",       64'(stall_cnt), 64'd0);

        // Stall counting and output stability
        out_ready = 1'b0;
        drive(1'b1, 'h33, 'h0A5);
        tick();
        drive(1'b0, 0, 0);
        check("t3_valid", 64'(out_valid), 64'd1);
        repeat (5) tick();
        check("t3_stall5",    64'(stall_cnt),    64'd5);
        check("t3_s3_stall5", 64'(s3_stall_cnt), 64'd5);
        check("t3_data",      64'(out_data),     64'h33);
        check("t3_ctrl",      64'(out_ctrl),     64'h0A5);
        repeat (5) tick();
        check("t3_stall10",   64'(stall_cnt),    64'd10);
        check("t3_s3_sat",    64'(s3_stall_cnt), 64'd7);
        check("t3_data2",     64'(out_data),     64'h33);
        check("t3_s3_data",   64'(s3_out_data),  64'h33);
        check("t3_s3_valid",  64'(s3_out_valid), 64'd1);
        check("t3_s3_ctrl",   64'(s3_out_ctrl),  64'h0A5);
        check("t3_s3_ready",  64'(s3_in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        check("t3_drain", 64'(out_valid), 64'd0);

        // Skid fill and ordered drain
        out_ready = 1'b0;
        drive(1'b1, 'hA, 1);
        tick();
        check("t2_dataA", 64'(out_data), 64'hA);
        check("t2_readyB", 64'(in_ready), 64'd1);
        drive(1'b1, 'hB, 2);
        tick();
        check("t2_full_ready", 64'(in_ready), 64'd0);
        check("t2_full_data",  64'(out_data), 64'hA);
        drive(1'b1, 'hEE, 3);
        tick();
        check("t2_hold_data",  64'(out_data), 64'hA);
        check("t2_hold_ctrl",  64'(out_ctrl), 64'd1);
        check("t2_hold_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 0, 0);
        out_ready = 1'b1;
        tick();
        check("t2_dataB",  64'(out_data),  64'hB);
        check("t2_ctrlB",  64'(out_ctrl),  64'd2);
        check("t2_validB", 64'(out_valid), 64'd1);
        check("t2_readyB2", 64'(in_ready), 64'd1);
        tick();
        check("t2_empty", 64'(out_valid), 64'd0);
        check("t2_nop",   64'(out_ctrl),  64'd0);
        check("t2_stall", 64'(stall_cnt), 64'd12);

        // Flush from FULL, then flush with a same-cycle accept in BUSY
        out_ready = 1'b0;
        drive(1'b1, 'hA, 1); tick();
        drive(1'b1, 'hB, 2); tick();
        flush = 1'b1;
        drive(1'b1, 'hC, 4);
        tick();
        check("t4_valid", 64'(out_valid), 64'd0);
        check("t4_nop",   64'(out_ctrl),  64'd0);
        check("t4_ready", 64'(in_ready),  64'd1);
        flush = 1'b0;
        drive(1'b0, 0, 0);
        out_ready = 1'b1;
        tick();
        check("t4_noC", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 'hD, 5); tick();
        flush = 1'b1;
        drive(1'b1, 'hC, 4);
        tick();
        check("t4b_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        drive(1'b0, 0, 0);
        tick();
        check("t4b_noC",  64'(out_valid), 64'd0);
        check("t4_stall", 64'(stall_cnt), 64'd15);

        // Reset in FULL, then clean restart
        drive(1'b1, 'hA, 1); tick();
        drive(1'b1, 'hB, 2); tick();
        rst_n = 1'b0;
        drive(1'b1, 'hC, 4);
        tick();
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_ctrl",  64'(out_ctrl),  64'd0);
        check("t5_data",  64'(out_data),  64'd0);
        check("t5_stall", 64'(stall_cnt), 64'd0);
        check("t5_ready", 64'(in_ready),  64'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, i, 7);
            tick();
            check("t5_data_seq", 64'(out_data), 64'(i));
        end
        drive(1'b0, 0, 0);
        tick();
        check("t5_end", 64'(out_valid), 64'd0);

        // Single-entry build: random handshakes against a queue model
        seq = '0;
        z_stalls = 0;
        for (int c = 0; c < 10000; c++) begin
            z_in_valid  = 1'($urandom_range(0, 1));
            z_out_ready = 1'($urandom_range(0, 1));
            z_in_ctrl   = 4'($urandom);
            z_in_data   = seq;
            #1;
            exp_v = (q.size() != 0);
            check("t6_valid", 64'(z_out_valid), 64'(exp_v));
            check("t6_ready", 64'(z_in_ready),  64'(!exp_v || z_out_ready));
            if (exp_v) begin
                check("t6_data", 64'(z_out_data), 64'(q[0][15:0]));
                check("t6_ctrl", 64'(z_out_ctrl), 64'(q[0][19:16]));
            end else begin
                check("t6_nop", 64'(z_out_ctrl), 64'd0);
            end
            acc = z_in_valid && (!exp_v || z_out_ready);
            dq  = exp_v && z_out_ready;
            if (exp_v && !z_out_ready) z_stalls++;
            if (dq) void'(q.pop_front());
            if (acc) begin
                q.push_back({z_in_ctrl, z_in_data});
                seq = seq + 16'd1;
            end
            tick();
        end
        check("t6_stall", 64'(z_stall_cnt), 64'(z_stalls));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
